// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Wide enough for any supported word size; users slice to DATA_SIZE.
    localparam logic [63:0] HALT_WORD = '1;

    localparam int unsigned FETCH_PC_W   = 16;
    localparam int unsigned FETCH_WORD_W = 32;

    // Queue entry layout at the default widths; pc sits above the word.
    typedef struct packed {
        logic [FETCH_PC_W-1:0]   pc;
        logic [FETCH_WORD_W-1:0] word;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Register-based FIFO with flush, bypass-on-full enqueue and
//               zeroed head outputs when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_can_push,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full     = (r_count == c_CNT_W'(DEPTH));
    assign o_valid    = (r_count != '0);
    assign w_pop      = i_pop && o_valid && !i_flush;
    // A full queue still accepts a word when the head leaves this cycle.
    assign o_can_push = !w_full || w_pop;
    assign w_push     = i_push && o_can_push && !i_flush;
    assign o_data     = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : PC/FSM front end feeding decode through fetch_queue.
//               Optional halt detection via macro FETCH_HALT_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                      DATA_SIZE    = 32,
    parameter int                      ADDRESS_SIZE = 16,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = '0,
    parameter int                      QUEUE_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_address,
    output logic [ADDRESS_SIZE-1:0] fetch_address,
    input  logic [DATA_SIZE-1:0]    fetch_data,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [DATA_SIZE-1:0]    instr_out,
    output logic [ADDRESS_SIZE-1:0] instr_pc,
    output logic                    busy
);

    typedef struct packed {
        logic [ADDRESS_SIZE-1:0] pc;
        logic [DATA_SIZE-1:0]    word;
    } entry_t;

    fetch_state_t            r_state;
    fetch_state_t            w_state_next;
    logic [ADDRESS_SIZE-1:0] r_pc;
    logic [ADDRESS_SIZE-1:0] w_pc_next;
    logic                    w_can_push;
    logic                    w_push;
    entry_t                  w_push_entry;
    entry_t                  w_head_entry;

    assign w_push       = (r_state == FETCH) && !redirect_valid && w_can_push;
    assign w_push_entry = '{pc: r_pc, word: fetch_data};

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        if (redirect_valid) begin
            w_state_next = FETCH;
            w_pc_next    = redirect_address;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_next = FETCH;
                    end
                end
                FETCH: begin
                    if (w_push) begin
                        w_pc_next = r_pc + ADDRESS_SIZE'(1);
`ifdef FETCH_HALT_DETECT_EN
                        if (fetch_data == HALT_WORD[DATA_SIZE-1:0]) begin
                            w_state_next = HALTED;
                        end
`endif
                    end
                end
                // HALTED only leaves through redirect or reset.
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    fetch_queue #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (redirect_valid),
        .i_push     (w_push),
        .i_data     (w_push_entry),
        .i_pop      (instr_ready),
        .o_can_push (w_can_push),
        .o_valid    (instr_valid),
        .o_data     (w_head_entry)
    );

    assign fetch_address = r_pc;
    assign instr_out     = w_head_entry.word;
    assign instr_pc      = w_head_entry.pc;
    assign busy          = (r_state == FETCH);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch with a behavioural Ram and
//               an in-order expected-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_address = '0;
    logic          instr_ready = 1'b0;
    logic [AW-1:0] fetch_address;
    logic [DW-1:0] fetch_data;
    logic          instr_valid;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          busy;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] word;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] m_next_pc = '0;
    bit            stream_on = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_pop = 0;

    instr_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .redirect_valid   (redirect_valid),
        .redirect_address (redirect_address),
        .fetch_address    (fetch_address),
        .fetch_data       (fetch_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_out        (instr_out),
        .instr_pc         (instr_pc),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    assign fetch_data = mem[fetch_address];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = $urandom;
        if (w == '1) w[0] = 1'b0;
        return w;
    endfunction

    // Expected stream: sequential words starting at the latest start/redirect PC.
    task automatic topup();
        while (sb.size() < 8) begin
            sb.push_back('{m_next_pc, mem[m_next_pc]});
            m_next_pc = m_next_pc + 1'b1;
        end
    endtask

    task automatic set_stream(input logic [AW-1:0] a);
        sb.delete();
        m_next_pc = a;
        stream_on = 1'b1;
        topup();
    endtask

    always @(posedge clk) begin
        if (stream_on) topup();
    end

    // Monitor: every accepted head must be the next word of the expected stream.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !instr_valid) begin
            check("empty_head_zero", {instr_pc, instr_out}, '0);
        end
        if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            n_pop++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_instr: got pc %0h, nothing expected", instr_pc);
            end else begin
                e = sb.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr_out", instr_out, e.word);
            end
        end
    end

    task automatic do_redirect(input logic [AW-1:0] a);
        redirect_valid   = 1'b1;
        redirect_address = a;
        set_stream(a);
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] fa_hold;
        for (int i = 0; i < (1 << AW); i++) mem[i] = rand_word();
        for (int i = 0; i < 4; i++) mem[i] = 32'hA000_0000 + i;

        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", instr_valid, 0);
        check("rst_out", instr_out, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_busy", busy, 0);
        check("rst_fetch_addr", fetch_address, 0);
        rst_n = 1'b1;
        tick();

        // Start with decode always ready: one instruction per cycle.
        instr_ready = 1'b1;
        start = 1'b1;
        set_stream(0);
        tick();
        start = 1'b0;
        check("start_valid_lat", instr_valid, 0);
        check("start_busy", busy, 1);
        check("start_fetch_addr", fetch_address, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stream_valid", instr_valid, 1);
            check("stream_pc", instr_pc, k);
        end

        // Backpressure: queue fills at two entries and PC holds.
        instr_ready = 1'b0;
        do_redirect(0);
        repeat (5) tick();
        check("full_fetch_addr", fetch_address, 2);
        check("full_valid", instr_valid, 1);
        check("full_head_pc", instr_pc, 0);
        instr_ready = 1'b1;
        repeat (4) tick();

        // Redirect with a full queue.
        instr_ready = 1'b0;
        repeat (3) tick();
        check("pre_redir_valid", instr_valid, 1);
        do_redirect(16'h0040);
        check("redir_flush", instr_valid, 0);
        tick();
        check("redir_valid", instr_valid, 1);
        check("redir_pc", instr_pc, 16'h0040);

        // PC wrap.
        instr_ready = 1'b1;
        do_redirect(16'hFFFF);
        tick();
        check("wrap_pc_hi", instr_pc, 16'hFFFF);
        tick();
        check("wrap_pc_lo", instr_pc, 16'h0000);

        // start outside IDLE is ignored.
        instr_ready = 1'b0;
        repeat (3) tick();
        fa_hold = fetch_address;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_addr", fetch_address, fa_hold);
        check("start_ignored_busy", busy, 1);

        // Asynchronous reset mid-stream.
        instr_ready = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        stream_on = 1'b0;
        sb.delete();
        #1;
        check("arst_valid", instr_valid, 0);
        check("arst_out", instr_out, 0);
        check("arst_pc", instr_pc, 0);
        check("arst_busy", busy, 0);
        check("arst_fetch_addr", fetch_address, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_valid", instr_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_fetch_addr", fetch_address, 0);

        // All-ones word at address 2.
        mem[2] = '1;
        n_pop = 0;
        start = 1'b1;
        set_stream(0);
        tick();
        start = 1'b0;
        repeat (8) tick();
`ifdef FETCH_HALT_DETECT_EN
        check("halt_pops", n_pop, 3);
        check("halt_busy", busy, 0);
        check("halt_fetch_addr", fetch_address, 3);
        check("halt_valid", instr_valid, 0);
`else
        check("nohalt_progress", n_pop >= 4, 1);
        check("nohalt_busy", busy, 1);
`endif
        do_redirect(0);
        tick();
        check("resume_valid", instr_valid, 1);
        check("resume_busy", busy, 1);
        check("resume_pc", instr_pc, 0);

        // Reset, restore an ordinary word, then random traffic.
        rst_n = 1'b0;
        stream_on = 1'b0;
        sb.delete();
        mem[2] = rand_word();
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        set_stream(0);
        tick();
        start = 1'b0;
        n_pop = 0;
        for (int c = 0; c < 3000; c++) begin
            instr_ready    = ($urandom_range(0, 9) < 7);
            start          = 1'b0;
            redirect_valid = 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                redirect_address = AW'($urandom);
                redirect_valid   = 1'b1;
                set_stream(redirect_address);
            end else if ($urandom_range(0, 29) == 0) begin
                start = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        check("random_progress", n_pop > 1000, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
